mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/bus_watchdog.sv | 41 ++++
 rtl/mem_bus_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding,
// read/write encoding of the RW lines and the default watchdog limit.
package mem_bus_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
   localparam logic [STATE_W-1:0] ST_GRANT    = 3'd1;
   localparam logic [STATE_W-1:0] ST_ACCESS   = 3'd2;
   localparam logic [STATE_W-1:0] ST_COMPLETE = 3'd3;
   localparam logic [STATE_W-1:0] ST_RELEASE  = 3'd4;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/bus_watchdog.sv
// ACCESS-phase watchdog. Counts enabled cycles starting at 1 and raises
// expired during the cycle in which the count equals LIMIT.
//   clk, reset  : clock, synchronous active-low reset
//   clear       : force count and expired to 0
//   enable      : the coming cycle is an ACCESS cycle; advance the count
//   expired     : current ACCESS cycle is number LIMIT
module bus_watchdog
   import mem_bus_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_inc;

   assign count_inc = count + CNT_W'(1);

   // expired is registered alongside the count so it aligns with the cycle
   // whose count value reaches LIMIT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (clear) begin
         count   <= '0;
         expired <= 1'b0;
      end else if (enable) begin
         count   <= count_inc;
         expired <= (count_inc == CNT_W'(LIMIT));
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter in front of a single MFC-handshaked memory.
// Port 0 is instruction fetch, port 1 is data load/store.
//   clk, reset               : clock, synchronous active-low reset
//   reqN, rwN, addrN, wdataN : requester side (rw 1 = read)
//   gntN, doneN, errN        : ownership, completion pulse, timeout pulse
//   rdata                    : last read data, updated when a read completes
//   mem_addr/wdata/rw/en     : memory-side MAR, MDR, RW and enable
//   mem_rdata, mfc           : memory read data and function-complete
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              rw0,
   input  logic              rw1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              err0,
   output logic              err1,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rw,
   output logic              mem_en,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mfc
);

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nxt;
   logic               owner;      // port being served; doubles as last-served pointer
   logic               owner_nxt;
   logic               timeout_hit;
   logic               busy_nxt;
   logic               wd_enable;
   logic               wd_clear;
   logic               wd_expired;

   bus_watchdog #(
      .LIMIT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // Next-state, arbitration and watchdog control.
   always_comb begin
      state_nxt   = state;
      owner_nxt   = owner;
      timeout_hit = 1'b0;

      case (state)
         ST_IDLE: begin
            if (req0 || req1) begin
               state_nxt = ST_GRANT;
               // Contention goes to the port not served last.
               owner_nxt = (req0 && req1) ? ~owner : req1;
            end
         end
         ST_GRANT:    state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (mfc) begin
               state_nxt = ST_COMPLETE;
            end else if (wd_expired) begin
               state_nxt   = ST_COMPLETE;
               timeout_hit = 1'b1;
            end
         end
         ST_COMPLETE: state_nxt = ST_RELEASE;
         ST_RELEASE: begin
            // Wait for the served request to drop so it is not serviced twice.
            if (!(owner ? req1 : req0)) state_nxt = ST_IDLE;
         end
         default:     state_nxt = ST_IDLE;
      endcase

      busy_nxt  = (state_nxt == ST_GRANT) || (state_nxt == ST_ACCESS) ||
                  (state_nxt == ST_COMPLETE);
      wd_enable = (state_nxt == ST_ACCESS);
      wd_clear  = ~wd_enable;
   end

   // State, registered outputs and request capture.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ST_IDLE;
         owner     <= 1'b1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         mem_en    <= 1'b0;
         mem_rw    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
      end else begin
         state  <= state_nxt;
         owner  <= owner_nxt;
         gnt0   <= busy_nxt & ~owner_nxt;
         gnt1   <= busy_nxt &  owner_nxt;
         done0  <= (state_nxt == ST_COMPLETE) & ~owner_nxt;
         done1  <= (state_nxt == ST_COMPLETE) &  owner_nxt;
         err0   <= timeout_hit & ~owner_nxt;
         err1   <= timeout_hit &  owner_nxt;
         mem_en <= (state_nxt == ST_ACCESS);

         // Requester fields are captured once, on GRANT entry.
         if ((state == ST_IDLE) && (state_nxt == ST_GRANT)) begin
            mem_addr  <= owner_nxt ? addr1  : addr0;
            mem_wdata <= owner_nxt ? wdata1 : wdata0;
            mem_rw    <= owner_nxt ? rw1    : rw0;
         end

         if ((state == ST_ACCESS) && mfc && (mem_rw == RW_READ)) begin
            rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: per-cycle vector tables plus a
// hand-written watchdog timeout sequence.
module tb_mem_bus_arbiter;

   logic       clk;
   logic       reset;
   logic       req0, req1, rw0, rw1;
   logic [7:0] addr0, addr1, wdata0, wdata1;
   logic       gnt0, gnt1, done0, done1, err0, err1;
   logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic       mem_rw, mem_en, mfc;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .ADDR_W  (8),
      .DATA_W  (8),
      .TIMEOUT (15)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req0      (req0),
      .req1      (req1),
      .rw0       (rw0),
      .rw1       (rw1),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .done0     (done0),
      .done1     (done1),
      .err0      (err0),
      .err1      (err1),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rw    (mem_rw),
      .mem_en    (mem_en),
      .mem_rdata (mem_rdata),
      .mfc       (mfc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs applied during a cycle; expected outputs after the next edge.
   // Two-bit fields are {port1, port0}.
   typedef struct {
      string      name;
      logic       rst;
      logic [1:0] req;
      logic [1:0] rw;
      logic [7:0] a0, a1, wd0, wd1;
      logic       mfc;
      logic [7:0] mrd;
      logic [1:0] gnt, done, err;
      logic       en, mrw;
      logic [7:0] maddr, mwd, rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(string nm, logic rst, logic [1:0] req, logic [1:0] rw,
                               logic [7:0] a0, logic [7:0] a1, logic [7:0] wd0, logic [7:0] wd1,
                               logic m, logic [7:0] mrd, logic [1:0] gnt, logic [1:0] done,
                               logic [1:0] err, logic en, logic mrw, logic [7:0] maddr,
                               logic [7:0] mwd, logic [7:0] rd);
      vec_t v;
      v.name = nm; v.rst = rst; v.req = req; v.rw = rw;
      v.a0 = a0; v.a1 = a1; v.wd0 = wd0; v.wd1 = wd1; v.mfc = m; v.mrd = mrd;
      v.gnt = gnt; v.done = done; v.err = err; v.en = en; v.mrw = mrw;
      v.maddr = maddr; v.mwd = mwd; v.rd = rd;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v);
      logic [31:0] act, exp;
      reset = v.rst;
      {req1, req0} = v.req;
      {rw1, rw0}   = v.rw;
      addr0 = v.a0; addr1 = v.a1; wdata0 = v.wd0; wdata1 = v.wd1;
      mfc = v.mfc; mem_rdata = v.mrd;
      tick();
      act = {gnt1, gnt0, done1, done0, err1, err0, mem_en, mem_rw, mem_addr, mem_wdata, rdata};
      exp = {v.gnt, v.done, v.err, v.en, v.mrw, v.maddr, v.mwd, v.rd};
      check(v.name, act, exp);
   endtask

   task automatic run_table();
      foreach (vecs[i]) apply(vecs[i]);
      vecs.delete();
   endtask

   // Both grants must never be high together.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         checks++;
         if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
            errors++;
            $display("FAIL gnt_exclusive: got gnt0=1 gnt1=1 expected at most one");
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit: got no finish expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int en_cnt;
      bit seen_done;

      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
      addr0 = 8'h00; addr1 = 8'h00; wdata0 = 8'h00; wdata1 = 8'h00;
      mfc = 1'b0; mem_rdata = 8'h00;

      // Reset, contention from reset release, fetch-only, second contention, write.
      vecs.push_back(mk("rst_a", 0, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk("rst_b", 0, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 1, 8'h99, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk("c1_grant0", 1, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 8'h20, 8'h00, 8'h00));
      vecs.push_back(mk("c2_access", 1, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h20, 8'h00, 8'h00));
      vecs.push_back(mk("c3_done0", 1, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 1, 8'h11, 2'b01, 2'b01, 2'b00, 0, 1, 8'h20, 8'h00, 8'h11));
      vecs.push_back(mk("c4_release", 1, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h20, 8'h00, 8'h11));
      vecs.push_back(mk("c5_hold", 1, 2'b11, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h20, 8'h00, 8'h11));
      vecs.push_back(mk("c6_idle", 1, 2'b10, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h20, 8'h00, 8'h11));
      vecs.push_back(mk("c7_grant1", 1, 2'b10, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 1, 8'h30, 8'h00, 8'h11));
      vecs.push_back(mk("c8_access", 1, 2'b10, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 1, 1, 8'h30, 8'h00, 8'h11));
      vecs.push_back(mk("c9_done1", 1, 2'b10, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 1, 8'h22, 2'b10, 2'b10, 2'b00, 0, 1, 8'h30, 8'h00, 8'h22));
      vecs.push_back(mk("c10_release", 1, 2'b00, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h30, 8'h00, 8'h22));
      vecs.push_back(mk("c11_idle", 1, 2'b00, 2'b11, 8'h20, 8'h30, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h30, 8'h00, 8'h22));
      vecs.push_back(mk("f1_grant", 1, 2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 8'h10, 8'h00, 8'h22));
      vecs.push_back(mk("f2_access", 1, 2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h10, 8'h00, 8'h22));
      vecs.push_back(mk("f3_wait", 1, 2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h10, 8'h00, 8'h22));
      vecs.push_back(mk("f4_wait", 1, 2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h10, 8'h00, 8'h22));
      vecs.push_back(mk("f5_done0", 1, 2'b01, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 1, 8'hA5, 2'b01, 2'b01, 2'b00, 0, 1, 8'h10, 8'h00, 8'hA5));
      vecs.push_back(mk("f6_release", 1, 2'b00, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h10, 8'h00, 8'hA5));
      vecs.push_back(mk("f7_idle", 1, 2'b00, 2'b01, 8'h10, 8'h00, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h10, 8'h00, 8'hA5));
      vecs.push_back(mk("b1_grant1", 1, 2'b11, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 1, 8'h50, 8'h00, 8'hA5));
      vecs.push_back(mk("b2_access", 1, 2'b11, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 1, 1, 8'h50, 8'h00, 8'hA5));
      vecs.push_back(mk("b3_done1", 1, 2'b11, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 1, 8'h33, 2'b10, 2'b10, 2'b00, 0, 1, 8'h50, 8'h00, 8'h33));
      vecs.push_back(mk("b4_release", 1, 2'b01, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h50, 8'h00, 8'h33));
      vecs.push_back(mk("b5_idle", 1, 2'b01, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h50, 8'h00, 8'h33));
      vecs.push_back(mk("b6_grant0", 1, 2'b01, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 8'h40, 8'h00, 8'h33));
      vecs.push_back(mk("b7_access", 1, 2'b01, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h40, 8'h00, 8'h33));
      vecs.push_back(mk("b8_done0", 1, 2'b01, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 1, 8'h44, 2'b01, 2'b01, 2'b00, 0, 1, 8'h40, 8'h00, 8'h44));
      vecs.push_back(mk("b9_release", 1, 2'b00, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h40, 8'h00, 8'h44));
      vecs.push_back(mk("b10_idle", 1, 2'b00, 2'b11, 8'h40, 8'h50, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h40, 8'h00, 8'h44));
      vecs.push_back(mk("w1_grant1", 1, 2'b10, 2'b01, 8'h40, 8'h3C, 8'h00, 8'h5A, 1, 8'hFF, 2'b10, 2'b00, 2'b00, 0, 0, 8'h3C, 8'h5A, 8'h44));
      vecs.push_back(mk("w2_access", 1, 2'b10, 2'b11, 8'h40, 8'h77, 8'h00, 8'h11, 1, 8'hFF, 2'b10, 2'b00, 2'b00, 1, 0, 8'h3C, 8'h5A, 8'h44));
      vecs.push_back(mk("w3_done1", 1, 2'b00, 2'b11, 8'h40, 8'h77, 8'h00, 8'h11, 1, 8'hFF, 2'b10, 2'b10, 2'b00, 0, 0, 8'h3C, 8'h5A, 8'h44));
      vecs.push_back(mk("w4_release", 1, 2'b00, 2'b11, 8'h40, 8'h77, 8'h00, 8'h11, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 8'h3C, 8'h5A, 8'h44));
      vecs.push_back(mk("w5_idle", 1, 2'b00, 2'b11, 8'h40, 8'h77, 8'h00, 8'h11, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 0, 8'h3C, 8'h5A, 8'h44));
      run_table();

      // Watchdog timeout on port 0 with mfc never asserted.
      reset = 1'b1; req0 = 1'b1; req1 = 1'b0; rw0 = 1'b1; addr0 = 8'h66; wdata0 = 8'h00;
      mfc = 1'b0; mem_rdata = 8'hEE;
      tick();
      check("to_grant", 32'({gnt0, mem_en, mem_addr}), 32'({1'b1, 1'b0, 8'h66}));
      en_cnt = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 40 && !seen_done; c++) begin
         tick();
         if (mem_en) en_cnt++;
         if (done0) seen_done = 1'b1;
      end
      check("to_done_seen", 32'(seen_done), 32'd1);
      check("to_en_cycles", 32'(en_cnt), 32'd15);
      check("to_done_err", 32'({done0, err0, gnt0, mem_en, done1, err1}), 32'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      check("to_rdata", 32'(rdata), 32'h44);
      req0 = 1'b0;
      tick();
      check("to_release", 32'({done0, err0, gnt0}), 32'd0);
      tick();

      // Reset in the middle of ACCESS, then sticky request handling.
      vecs.push_back(mk("r1_grant1", 1, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 1, 8'h77, 8'h00, 8'h44));
      vecs.push_back(mk("r2_access", 1, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 1, 1, 8'h77, 8'h00, 8'h44));
      vecs.push_back(mk("r3_reset", 0, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 1, 8'hEE, 2'b00, 2'b00, 2'b00, 0, 0, 8'h00, 8'h00, 8'h00));
      vecs.push_back(mk("r4_regrant", 1, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 1, 8'h77, 8'h00, 8'h00));
      vecs.push_back(mk("r5_access", 1, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 1, 1, 8'h77, 8'h00, 8'h00));
      vecs.push_back(mk("r6_done1", 1, 2'b10, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 1, 8'h5C, 2'b10, 2'b10, 2'b00, 0, 1, 8'h77, 8'h00, 8'h5C));
      vecs.push_back(mk("r7_release", 1, 2'b00, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h77, 8'h00, 8'h5C));
      vecs.push_back(mk("r8_idle", 1, 2'b00, 2'b11, 8'h66, 8'h77, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h77, 8'h00, 8'h5C));
      vecs.push_back(mk("s1_grant0", 1, 2'b01, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 0, 1, 8'h81, 8'h00, 8'h5C));
      vecs.push_back(mk("s2_access", 1, 2'b01, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 1, 1, 8'h81, 8'h00, 8'h5C));
      vecs.push_back(mk("s3_done0", 1, 2'b01, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 1, 8'h9A, 2'b01, 2'b01, 2'b00, 0, 1, 8'h81, 8'h00, 8'h9A));
      vecs.push_back(mk("s4_release", 1, 2'b01, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h81, 8'h00, 8'h9A));
      vecs.push_back(mk("s5_sticky", 1, 2'b11, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h81, 8'h00, 8'h9A));
      vecs.push_back(mk("s6_sticky", 1, 2'b11, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h81, 8'h00, 8'h9A));
      vecs.push_back(mk("s7_idle", 1, 2'b10, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h81, 8'h00, 8'h9A));
      vecs.push_back(mk("s8_grant1", 1, 2'b10, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 0, 1, 8'h82, 8'h00, 8'h9A));
      vecs.push_back(mk("s9_access", 1, 2'b10, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 1, 1, 8'h82, 8'h00, 8'h9A));
      vecs.push_back(mk("s10_done1", 1, 2'b10, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 1, 8'hBC, 2'b10, 2'b10, 2'b00, 0, 1, 8'h82, 8'h00, 8'hBC));
      vecs.push_back(mk("s11_release", 1, 2'b00, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h82, 8'h00, 8'hBC));
      vecs.push_back(mk("s12_idle", 1, 2'b00, 2'b11, 8'h81, 8'h82, 8'h00, 8'h00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 0, 1, 8'h82, 8'h00, 8'hBC));
      run_table();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
